// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared state encodings and sizing helper for the two-input round-robin arbiter.
// Grant states double as the one-hot grant vector driven to the outside.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_e;

    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_burst_counter.sv
// Beat counter for the active grant: clears on grant change, saturates at MAX_BURST.
// Registered count, at_max decoded from the register.
module mux2_rr_arbiter_burst_counter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter  int MAX_BURST = 4,
    localparam int CW        = burst_cnt_width(MAX_BURST)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 valid/ready arbiter with bounded bursts; accepted beat appears on out_* one cycle later.
// A held, unconsumed output beat forces both readies low; grant changes still follow requester valids.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int N         = 3,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready,
    output logic [1:0]   grant
);

    localparam int            CW      = burst_cnt_width(MAX_BURST);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    state_e        state_q;
    logic          last_q;
    logic          out_valid_q;
    logic [N-1:0]  out_data_q;
    logic          out_src_q;

    logic [CW-1:0] cnt;
    logic          at_max;
    logic          space;
    logic          cur_src;
    logic          cur_valid;
    logic          oth_valid;
    logic          cur_ready;
    logic          beat;
    logic          idle_start;
    logic          go_other;
    logic          go_idle;
    logic          clr;
    logic [N-1:0]  sel_data;

    always_comb begin
        space      = !out_valid_q || out_ready;
        cur_src    = (state_q == GRANT1);
        cur_valid  = cur_src ? req1_valid : req0_valid;
        oth_valid  = cur_src ? req0_valid : req1_valid;
        // Past the burst limit the grant holder only keeps going while nobody else waits.
        cur_ready  = (state_q != IDLE) && space && ((cnt < MAX_CNT) || !oth_valid);
        beat       = cur_ready && cur_valid;
        idle_start = (state_q == IDLE) && (req0_valid || req1_valid);
        go_other   = (state_q != IDLE) && oth_valid && (at_max || !cur_valid);
        go_idle    = (state_q != IDLE) && !cur_valid && !oth_valid;
        clr        = idle_start || go_other || go_idle;
        sel_data   = cur_src ? req1_data : req0_data;
    end

    mux2_rr_arbiter_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .inc    (beat),
        .cnt    (cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        state_q <= last_q ? GRANT0 : GRANT1;
                    end else if (req0_valid) begin
                        state_q <= GRANT0;
                    end else if (req1_valid) begin
                        state_q <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (go_other) begin
                        state_q <= cur_src ? GRANT0 : GRANT1;
                        last_q  <= cur_src;
                    end else if (go_idle) begin
                        state_q <= IDLE;
                        last_q  <= cur_src;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else if (beat) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= cur_src;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign req0_ready = cur_ready && !cur_src;
    assign req1_ready = cur_ready && cur_src;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign grant      = state_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed vector table, contention/reset sequences, random scoreboard.
module tb_mux2_rr_arbiter;

    localparam int N         = 3;
    localparam int MAX_BURST = 4;

    logic         clk;
    logic         reset;
    logic         req0_valid;
    logic [N-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_data;
    logic         req1_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_src;
    logic         out_ready;
    logic [1:0]   grant;

    mux2_rr_arbiter #(
        .N         (N),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v0;
        logic [N-1:0] d0;
        logic         v1;
        logic [N-1:0] d1;
        logic         ordy;
        logic [8:0]   exp;   // {r0, r1, out_valid, out_data, out_src, grant}
    } vec_t;

    vec_t         vecs[$];
    int           n_cmp;
    int           n_bad;
    logic [N-1:0] q0[$];
    logic [N-1:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input int v0, input int d0, input int v1, input int d1, input int ordy,
                           input int r0, input int r1, input int ov, input int od, input int src,
                           input int g);
        vec_t v;
        v.v0   = 1'(v0);
        v.d0   = N'(d0);
        v.v1   = 1'(v1);
        v.d1   = N'(d1);
        v.ordy = 1'(ordy);
        v.exp  = {1'(r0), 1'(r1), 1'(ov), N'(od), 1'(src), 2'(g)};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic v0, input logic [N-1:0] d0, input logic v1,
                         input logic [N-1:0] d1, input logic ordy);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [8:0] obs();
        return {req0_ready, req1_ready, out_valid, out_data, out_src, grant};
    endfunction

    initial begin
        logic acc0;
        logic acc1;
        int   seq0;
        int   seq1;
        int   run_len;
        logic [1:0] prev_grant;
        logic [1:0] exp_rdy;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_state", obs(), 9'd0);

        // Single requester, saturation, backpressure, drain+refill, idle, early release.
        //      v0 d0 v1 d1 or | r0 r1 ov od src g
        add_vec(1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1);
        add_vec(1, 2, 0, 0, 1,   1, 0, 1, 1, 0, 1);
        add_vec(1, 3, 0, 0, 1,   1, 0, 1, 2, 0, 1);
        add_vec(1, 4, 0, 0, 1,   1, 0, 1, 3, 0, 1);
        add_vec(1, 5, 0, 0, 1,   1, 0, 1, 4, 0, 1);
        add_vec(1, 6, 0, 0, 1,   1, 0, 1, 5, 0, 1);
        add_vec(1, 7, 0, 0, 0,   0, 0, 1, 6, 0, 1);
        add_vec(1, 7, 0, 0, 0,   0, 0, 1, 6, 0, 1);
        add_vec(1, 7, 0, 0, 0,   0, 0, 1, 6, 0, 1);
        add_vec(1, 7, 0, 0, 0,   0, 0, 1, 6, 0, 1);
        add_vec(1, 7, 0, 0, 0,   0, 0, 1, 6, 0, 1);
        add_vec(1, 7, 0, 0, 1,   1, 0, 1, 6, 0, 1);
        add_vec(0, 0, 0, 0, 1,   1, 0, 1, 7, 0, 1);
        add_vec(0, 0, 1, 5, 1,   0, 0, 0, 7, 0, 0);
        add_vec(1, 1, 1, 5, 1,   0, 1, 0, 7, 0, 2);
        add_vec(1, 1, 1, 6, 1,   0, 1, 1, 5, 1, 2);
        add_vec(1, 1, 0, 0, 1,   0, 1, 1, 6, 1, 2);
        add_vec(1, 1, 0, 0, 1,   1, 0, 0, 6, 1, 1);
        add_vec(0, 0, 0, 0, 1,   1, 0, 1, 1, 0, 1);
        add_vec(0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Contention: both valid forever -> bursts of MAX_BURST with one gap per switch.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            drive(1'b1, 3'd2, 1'b1, 3'd5, 1'b1);
            @(negedge clk);
            if (i == 0 || ((i - 1) % (MAX_BURST + 1)) == MAX_BURST) exp_rdy = 2'b00;
            else if ((((i - 1) / (MAX_BURST + 1)) % 2) == 0) exp_rdy = 2'b10;
            else exp_rdy = 2'b01;
            chk($sformatf("contend%0d", i), {req0_ready, req1_ready}, exp_rdy);
        end

        // Reset in the middle of a req0 burst with a held output beat.
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_reset_held", {out_valid, grant}, 3'b1_01);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset", {out_valid, out_data, grant, req0_ready, req1_ready}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("first_grant_after_reset", {req0_ready, req1_ready, grant}, 4'b10_01);

        // Random traffic against a per-source in-order scoreboard.
        do_reset();
        acc0       = 1'b0;
        acc1       = 1'b0;
        seq0       = 0;
        seq1       = 0;
        run_len    = 0;
        prev_grant = 2'b00;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                if (req0_valid) begin
                    req0_data = N'(seq0);
                    seq0++;
                end
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                if (req1_valid) begin
                    req1_data = N'(seq1);
                    seq1++;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            chk("single_ready", 32'(req0_ready && req1_ready), 32'd0);
            chk("occupancy", 32'(q0.size() + q1.size()), 32'(out_valid));
            if (out_valid) begin
                if (out_src == 1'b0) begin
                    if (q0.size() > 0) begin
                        chk("order_src0", 32'(out_data), 32'(q0[0]));
                        if (out_ready) void'(q0.pop_front());
                    end
                end else begin
                    if (q1.size() > 0) begin
                        chk("order_src1", 32'(out_data), 32'(q1[0]));
                        if (out_ready) void'(q1.pop_front());
                    end
                end
            end

            if (grant != prev_grant) run_len = 0;
            prev_grant = grant;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0) begin
                if (req1_valid) chk("burst_bound0", 32'(run_len < MAX_BURST), 32'd1);
                run_len++;
                q0.push_back(req0_data);
            end
            if (acc1) begin
                if (req0_valid) chk("burst_bound1", 32'(run_len < MAX_BURST), 32'd1);
                run_len++;
                q1.push_back(req1_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
